// File: rtl/occupancy_display.sv
// Parking-lot occupancy display: 4-digit multiplexed 7-segment driver showing
// occupancy, free spaces and a 2-digit BCD entry total, blanking while full.
module occupancy_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 6000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] count,
   input  logic       inc_pulse,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       full_led
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);

   logic [RW-1:0] refresh_cnt;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [1:0]    digit_idx;
   logic [3:0]    ones;
   logic [3:0]    tens;

   logic [3:0]    digit_val;
   logic [3:0]    an_next;
   logic          is_full;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign is_full = (count == 3'd7);

   always_comb begin
      digit_val = 4'd0;
      an_next   = 4'b1111;
      case (digit_idx)
         2'd0: begin digit_val = {1'b0, count};         an_next = 4'b1110; end
         2'd1: begin digit_val = {1'b0, 3'd7 - count};  an_next = 4'b1101; end
         2'd2: begin digit_val = ones;                  an_next = 4'b1011; end
         default: begin digit_val = tens;               an_next = 4'b0111; end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_cnt <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         digit_idx   <= 2'd0;
         ones        <= 4'd0;
         tens        <= 4'd0;
         seg         <= 7'b1111111;
         an          <= 4'b1111;
         full_led    <= 1'b0;
      end else begin
         // Outputs use the pre-edge index/count/total, giving one cycle of latency.
         an       <= an_next;
         seg      <= (is_full && blink_phase) ? 7'b1111111 : seg_code(digit_val);
         full_led <= is_full;

         if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end

         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         // Every high cycle of inc_pulse is one entry, counted even while full.
         if (inc_pulse) begin
            if (ones == 4'd9) begin
               ones <= 4'd0;
               tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
               ones <= ones + 4'd1;
            end
         end
      end
   end

endmodule

// File: doc/occupancy_display.md
OCCUPANCY_DISPLAY -- requirements
Module: occupancy_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles each digit is held before the multiplexer advances (min 2).
REQ-002 Parameter BLINK_DIV, default 6000000, clk cycles per blink half-period (min 2).
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port count  input  3  current occupancy from the lot counter, 0..7; capacity is 7.
REQ-006 Port inc_pulse  input  1  one-cycle pulse per accepted vehicle entry.
REQ-007 Port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 Port an  output  4  digit anodes, active-low, one-hot-low, registered.
REQ-009 Port full_led  output  1  high while count == 7, registered.

Function
REQ-010 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on its terminal value the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-011 Digit 0 (an=4'b1110) SHALL show count (occupancy).
REQ-012 Digit 1 (an=4'b1101) SHALL show free spaces = 7 - count, computed in 3 bits (never negative).
REQ-013 Digit 2 (an=4'b1011) SHALL show entry-total ones BCD digit; digit 3 (an=4'b0111) the tens BCD digit.
REQ-014 Entry total SHALL be a 2-digit BCD counter, +1 per clk cycle in which inc_pulse = 1; ones 9 -> 0 with tens carry; 99 -> 00 wrap.
REQ-015 inc_pulse held high N cycles SHALL count N entries (no edge detection in this block).
REQ-016 seg encodings (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 seg and an SHALL be registered: they reflect the digit index, count and entry total sampled on the previous clk edge (1-cycle latency).
REQ-018 Blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on its terminal value, free-running regardless of count.
REQ-019 When count == 7 and blink_phase == 1, seg SHALL be 7'b1111111 (blank) for all digits; an SHALL keep scanning.
REQ-020 When count < 7, blink_phase SHALL have no effect on seg.
REQ-021 full_led SHALL equal (count == 7) delayed one clk cycle; it SHALL NOT blink.
REQ-022 Exactly one an bit SHALL be low in every cycle after the first post-reset edge.
REQ-023 The entry total SHALL NOT depend on count; entries while full are still counted.

Reset
REQ-024 While reset = 1: an = 4'b1111, seg = 7'b1111111, full_led = 0, entry total = 00, digit index = 0, refresh and blink counters = 0, blink_phase = 0.
REQ-025 On reset assertion, outputs SHALL change asynchronously without waiting for clk.
REQ-026 After reset deassertion, the first clk edge SHALL drive an = 4'b1110 with the count digit.
REQ-027 inc_pulse coincident with reset SHALL be discarded.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-028 Reset release, count=3 -> first edge an=1110 seg=0110000; after 4 more edges an=1101 seg=0011001 (free 4).
REQ-029 10 inc_pulse cycles from reset -> digit 2 seg=1000000, digit 3 seg=1111001 (total 10).
REQ-030 100 inc_pulse cycles -> total wraps to 00; digits 2 and 3 both seg=1000000.
REQ-031 count=7 -> full_led=1 next edge; seg alternates between digit codes and 1111111 every 8 cycles while an keeps scanning; count=6 -> blinking stops, full_led=0.
REQ-032 count=0 -> digit 0 seg=1000000, digit 1 seg=1111000 (free 7); no blanking.
REQ-033 reset asserted mid-scan between clk edges, total=57 -> an=1111, seg=1111111 immediately; after release total reads 00.
